// File: rtl/fpu_pkg.sv
// ============================================================================
// Module  : fpu_pkg
// Purpose : Shared types and constants for the FPU issue sequencer: op codes,
//           sequencer states, the timeout result value and op classifiers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  typedef enum logic [3:0] {
    FP_ADD = 4'd0,
    FP_SUB = 4'd1,
    FP_DIV = 4'd2,
    FP_MUL = 4'd3,
    FP_ABS = 4'd5,
    FP_NEG = 4'd7
  } fp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  // Quiet NaN returned when an op is aborted by the watchdog
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Ops executed by the multi-cycle units, qualified by the finish flag
  function automatic logic is_multi_cycle(input logic [3:0] funct);
    return (funct == FP_ADD) || (funct == FP_SUB) ||
           (funct == FP_DIV) || (funct == FP_MUL);
  endfunction

  // Sign-bit ops whose result is valid one cycle after launch
  function automatic logic is_single_cycle(input logic [3:0] funct);
    return (funct == FP_ABS) || (funct == FP_NEG);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_watchdog.sv
// ============================================================================
// Module  : fpu_watchdog
// Purpose : Busy-cycle counter for the FPU sequencer. Reports when the finish
//           flag may be trusted (settled) and when the op must be abandoned
//           (expired). Saturates at TIMEOUT-1 so it never wraps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_watchdog #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic settled,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Count busy cycles; clear takes priority, hold once the last value is hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_LAST)) begin
      count <= count + CNT_ONE;
    end
  end

  assign settled = (count >= CNT_SETTLE);
  assign expired = (count == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/fpu_op_sequencer.sv
// ============================================================================
// Module  : fpu_op_sequencer
// Purpose : Issue controller between the EX stage and the multi-cycle FPU.
//           Accepts one op at a time, holds FPU operands stable, stalls the
//           pipeline, qualifies finish, enforces a timeout and returns the
//           result with a one-cycle writeback strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [3:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  input  logic        flush,
  output logic        stall,
  output logic [3:0]  fpu_funct,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic        fpu_finish,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_illegal,
  output logic        err_timeout
);

  seq_state_e  state;
  logic [4:0]  rd_q;
  logic        accept;
  logic        wd_clear;
  logic        wd_enable;
  logic        settled;
  logic        expired;

  assign stall     = (state != IDLE);
  assign req_ready = (state == IDLE) && !flush;
  assign accept    = req_ready && req_valid;
  assign wd_clear  = (state != BUSY);
  assign wd_enable = (state == BUSY);

  fpu_watchdog #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .settled (settled),
    .expired (expired)
  );

  // Sequencer FSM with registered FPU launch, writeback and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_q        <= '0;
      fpu_funct   <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            fpu_funct <= req_funct;
            fpu_a     <= req_a;
            fpu_b     <= req_b;
            rd_q      <= req_rd;
            if (is_multi_cycle(req_funct)) begin
              state <= BUSY;
            end else if (is_single_cycle(req_funct)) begin
              state <= EXEC;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            wb_data  <= fpu_result;
            wb_rd    <= rd_q;
            wb_valid <= 1'b1;
            state    <= DONE;
          end
        end
        BUSY: begin
          // A finish seen in the timeout cycle still counts as a good result
          if (flush) begin
            state <= IDLE;
          end else if (settled && fpu_finish) begin
            wb_data  <= fpu_result;
            wb_rd    <= rd_q;
            wb_valid <= 1'b1;
            state    <= DONE;
          end else if (expired) begin
            wb_data     <= FP_QNAN;
            wb_rd       <= rd_q;
            wb_valid    <= 1'b1;
            err_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
// ============================================================================
// Module  : tb_fpu_op_sequencer
// Purpose : Self-checking bench for fpu_op_sequencer: directed scenarios plus
//           randomized ops compared against a cycle-level outcome model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_op_sequencer;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_funct = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic [31:0] fpu_result = 32'd0;
  logic        fpu_finish = 1'b0;
  logic        req_ready;
  logic        stall;
  logic [3:0]  fpu_funct;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_illegal;
  logic        err_timeout;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_a = 32'd0;

  always #5 clk = ~clk;

  fpu_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_funct   (req_funct),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_rd      (req_rd),
    .req_ready   (req_ready),
    .flush       (flush),
    .stall       (stall),
    .fpu_funct   (fpu_funct),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_result  (fpu_result),
    .fpu_finish  (fpu_finish),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // FPU behaviour for cycle t after launch: finish is high through cycle s
  // (stale flag from the previous op) and again from cycle r onward, when
  // the new result is on the bus.
  function automatic logic fin_at(input int t, input int s, input int r);
    return (t <= s) || (t >= r);
  endfunction

  function automatic logic [31:0] res_at(input int t, input int r,
                                         input logic [31:0] old_res, input logic [31:0] new_res);
    return (t >= r) ? new_res : old_res;
  endfunction

  // Issue one op at cycle 0 and follow it until the sequencer is idle again.
  // Called and returns at negedge+1.
  task automatic run_op(input string tag, input logic [3:0] funct,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int s, input int r,
                        input logic [31:0] old_res, input logic [31:0] new_res,
                        input int flush_at);
    bit          multi;
    bit          single;
    bit          illegal;
    bit          timed_out;
    bit          flushed;
    int          wb_t;
    int          end_t;
    int          stall_last;
    logic [31:0] exp_data;
    logic [4:0]  exp_ctrl;

    multi     = funct inside {4'd0, 4'd1, 4'd2, 4'd3};
    single    = funct inside {4'd5, 4'd7};
    illegal   = !multi && !single;
    wb_t      = 0;
    timed_out = 1'b0;
    exp_data  = 32'd0;
    if (single) begin
      wb_t     = 2;
      exp_data = res_at(1, r, old_res, new_res);
    end else if (multi) begin
      // Finish is trusted from the third busy cycle (cycle 3) to the 64th (cycle 64)
      wb_t      = 65;
      exp_data  = QNAN;
      timed_out = 1'b1;
      for (int t = 64; t >= 3; t--) begin
        if (fin_at(t, s, r)) begin
          wb_t      = t + 1;
          exp_data  = res_at(t, r, old_res, new_res);
          timed_out = 1'b0;
        end
      end
    end
    flushed = !illegal && (flush_at >= 1) && (flush_at < wb_t);
    if (illegal) begin
      end_t = 1; stall_last = 0;
    end else if (flushed) begin
      end_t = flush_at + 1; stall_last = flush_at;
    end else begin
      end_t = wb_t + 1; stall_last = wb_t;
    end

    check({tag, ":ready0"}, 128'(req_ready), 128'(1'b1));
    req_valid  = 1'b1;
    req_funct  = funct;
    req_a      = a;
    req_b      = b;
    req_rd     = rd;
    flush      = 1'b0;
    fpu_finish = fin_at(0, s, r);
    fpu_result = res_at(0, r, old_res, new_res);
    last_a     = a;

    for (int t = 1; t <= end_t; t++) begin
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      #1;
      exp_ctrl = {(!flushed && !illegal && t == wb_t),
                  (t <= stall_last),
                  (timed_out && !flushed && t == wb_t),
                  (illegal && t == 1),
                  (t > stall_last)};
      check({tag, ":ctrl"}, 128'({wb_valid, stall, err_timeout, err_illegal, req_ready}),
            128'(exp_ctrl));
      if (t == 1 || t == end_t)
        check({tag, ":operands"}, 128'({fpu_funct, fpu_a, fpu_b}), 128'({funct, a, b}));
      if (!flushed && !illegal && t == wb_t)
        check({tag, ":wb"}, 128'({wb_rd, wb_data}), 128'({rd, exp_data}));
      if (t < end_t) begin
        fpu_finish = fin_at(t, s, r);
        fpu_result = res_at(t, r, old_res, new_res);
        flush      = (t == flush_at);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] op_tab [9];
    op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd4, 4'd6, 4'd12};

    // Reset state
    #3;
    check("reset", 128'({stall, wb_valid, err_timeout, err_illegal, req_ready,
                         fpu_funct, fpu_a, fpu_b, wb_rd, wb_data}),
          128'({4'b0000, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // ADD with finish 5 cycles after launch
    run_op("add", 4'd0, 32'h3FC0_0000, 32'h4010_0000, 5'd9, -1, 5, 32'd0, 32'h4070_0000, -1);
    // Sign ops
    run_op("neg", 4'd7, 32'h3F80_0000, 32'd0, 5'd3, -1, 1, 32'd0, 32'hBF80_0000, -1);
    run_op("abs", 4'd5, 32'hC049_0FDB, 32'd0, 5'd30, -1, 1, 32'd0, 32'h4049_0FDB, -1);
    // Stale finish held from previous op, dropped, then re-raised with new result
    run_op("mul_stale", 4'd3, 32'h4000_0000, 32'h4040_0000, 5'd12, 2, 4,
           32'h4070_0000, 32'h40C0_0000, -1);
    // Finish never arrives
    run_op("div_timeout", 4'd2, 32'h3F80_0000, 32'd0, 5'd21, -1, 1000, 32'h1111_1111, 32'd0, -1);
    // Finish arrives exactly in the timeout cycle
    run_op("sub_lastcycle", 4'd1, 32'h4100_0000, 32'h3F80_0000, 5'd7, -1, 64,
           32'h2222_2222, 32'h40E0_0000, -1);
    // Flush in the fourth busy cycle, then a normal ADD
    run_op("div_flush", 4'd2, 32'h4120_0000, 32'h4000_0000, 5'd5, -1, 1000, 32'd0, 32'd0, 4);
    run_op("add_after_flush", 4'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd1, -1, 3,
           32'd0, 32'h4000_0000, -1);
    // Flush during DONE is ignored
    run_op("neg_flush_done", 4'd7, 32'h4000_0000, 32'd0, 5'd2, -1, 1, 32'd0, 32'hC000_0000, 2);
    // Unsupported funct
    run_op("illegal4", 4'd4, 32'h0BAD_F00D, 32'h1234_5678, 5'd19, -1, 1, 32'd0, 32'd0, -1);

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; req_funct = 4'd0; req_a = 32'hDEAD_BEEF; req_b = 32'h1; flush = 1'b1;
    #1;
    check("idle_flush_ready", 128'(req_ready), 128'(1'b0));
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush_held", 128'({stall, fpu_a}), 128'({1'b0, last_a}));

    // Asynchronous reset in the middle of a MUL
    req_valid = 1'b1; req_funct = 4'd3; req_a = 32'h4080_0000; req_b = 32'h4080_0000;
    req_rd = 5'd17; fpu_finish = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid", 128'({stall, wb_valid, err_timeout, err_illegal, req_ready,
                           fpu_funct, fpu_a, fpu_b, wb_rd, wb_data}),
          128'({4'b0000, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 32'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    fpu_finish = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("rst_after", 128'({wb_valid, stall, req_ready}), 128'(3'b001));
    end
    fpu_finish = 1'b0;

    // Randomized ops
    for (int i = 0; i < 24; i++) begin
      logic [3:0] f;
      int         s;
      int         r;
      int         fa;
      f  = op_tab[$urandom_range(0, 8)];
      s  = int'($urandom_range(0, 5)) - 1;
      r  = int'($urandom_range(1, 70));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_op("rand", f, $urandom, $urandom, 5'($urandom_range(0, 31)), s, r,
             $urandom, $urandom, fa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
